// File: rtl/alu_result_stage.sv
// alu_result_stage: EX/MEM result register with MIPS signed-overflow trap handling
module alu_result_stage #(
   parameter bit TRAP_EN = 1'b1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [31:0]      in_S,
   input  logic             in_Z,
   input  logic             in_V,
   input  logic             in_N,
   input  logic             in_sign,
   input  logic             in_wr_en,
   input  logic [4:0]       in_wr_addr,
   input  logic [31:0]      in_pc,
   input  logic             stall,
   input  logic             flush,
   input  logic             exc_ack,
   output logic             out_valid,
   output logic [31:0]      out_S,
   output logic             out_Z,
   output logic             out_V,
   output logic             out_N,
   output logic             out_wr_en,
   output logic [4:0]       out_wr_addr,
   output logic             exc_req,
   output logic [31:0]      exc_pc,
   output logic             busy,
   output logic [CNT_W-1:0] trap_cnt
);
   typedef enum logic {RUN, TRAP} state_t;
   state_t r_state, w_state_next;
   logic             r_valid, r_Z, r_V, r_N, r_wr_en, r_exc_req;
   logic [31:0]      r_S, r_exc_pc;
   logic [4:0]       r_wr_addr;
   logic [CNT_W-1:0] r_cnt;
   logic             w_run, w_cap, w_trap, w_take;
   assign w_run  = (r_state == RUN);
   assign w_cap  = w_run & ~flush & ~stall & in_valid;
   assign w_trap = TRAP_EN & in_sign & in_V;
   assign w_take = w_cap & w_trap;
   // Next state: enter TRAP on a captured overflow, leave it only on CP0 acknowledge
   always_comb begin
      w_state_next = w_run ? (w_take ? TRAP : RUN) : (exc_ack ? RUN : TRAP);
   end
   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= RUN;
      else       r_state <= w_state_next;
   end
   // Result/flag pipeline register and exception request; TRAP squashes the stage until acked
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid   <= 1'b0;
         r_S       <= '0;
         r_Z       <= 1'b0;
         r_V       <= 1'b0;
         r_N       <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_exc_req <= 1'b0;
         r_exc_pc  <= '0;
      end else if (!w_run) begin
         r_valid <= 1'b0;
         r_wr_en <= 1'b0;
         if (exc_ack) r_exc_req <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_wr_en <= 1'b0;
      end else if (!stall) begin
         if (in_valid) begin
            r_valid   <= 1'b1;
            r_S       <= in_S;
            r_Z       <= in_Z;
            r_V       <= in_V;
            r_N       <= in_N;
            r_wr_addr <= in_wr_addr;
            r_wr_en   <= in_wr_en & ~w_trap;
            if (w_trap) begin
               r_exc_req <= 1'b1;
               r_exc_pc  <= in_pc;
            end
         end else begin
            r_valid <= 1'b0;
            r_wr_en <= 1'b0;
         end
      end
   end
   // Saturating count of traps taken
   always_ff @(posedge clk) begin
      if (reset)                  r_cnt <= '0;
      else if (w_take && ~&r_cnt) r_cnt <= r_cnt + CNT_W'(1);
   end
   assign out_valid   = r_valid;
   assign out_S       = r_S;
   assign out_Z       = r_Z;
   assign out_V       = r_V;
   assign out_N       = r_N;
   assign out_wr_en   = r_wr_en;
   assign out_wr_addr = r_wr_addr;
   assign exc_req     = r_exc_req;
   assign exc_pc      = r_exc_pc;
   assign busy        = ~w_run;
   assign trap_cnt    = r_cnt;
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: scoreboard bench for alu_result_stage (default and 2-bit counter builds)
module tb_alu_result_stage;
   logic        clk = 1'b0;
   logic        reset, in_valid, in_Z, in_V, in_N, in_sign, in_wr_en, stall, flush, exc_ack;
   logic [31:0] in_S, in_pc;
   logic [4:0]  in_wr_addr;
   logic        out_valid, out_Z, out_V, out_N, out_wr_en, exc_req, busy;
   logic [31:0] out_S, exc_pc;
   logic [4:0]  out_wr_addr;
   logic [15:0] trap_cnt;
   logic        s_valid, s_Z, s_V, s_N, s_wr_en, s_exc_req, s_busy;
   logic [31:0] s_S, s_exc_pc;
   logic [4:0]  s_wr_addr;
   logic [1:0]  s_cnt;
   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   alu_result_stage u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_S(in_S), .in_Z(in_Z), .in_V(in_V),
      .in_N(in_N), .in_sign(in_sign), .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_pc(in_pc),
      .stall(stall), .flush(flush), .exc_ack(exc_ack), .out_valid(out_valid), .out_S(out_S),
      .out_Z(out_Z), .out_V(out_V), .out_N(out_N), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
      .exc_req(exc_req), .exc_pc(exc_pc), .busy(busy), .trap_cnt(trap_cnt));

   alu_result_stage #(.CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_S(in_S), .in_Z(in_Z), .in_V(in_V),
      .in_N(in_N), .in_sign(in_sign), .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_pc(in_pc),
      .stall(stall), .flush(flush), .exc_ack(exc_ack), .out_valid(s_valid), .out_S(s_S),
      .out_Z(s_Z), .out_V(s_V), .out_N(s_N), .out_wr_en(s_wr_en), .out_wr_addr(s_wr_addr),
      .exc_req(s_exc_req), .exc_pc(s_exc_pc), .busy(s_busy), .trap_cnt(s_cnt));

   typedef struct packed {
      logic        valid;
      logic [31:0] s;
      logic        z, v, n, wr_en;
      logic [4:0]  addr;
      logic        exc_req;
      logic [31:0] epc;
      logic        busy;
   } snap_t;

   snap_t       m;
   int unsigned m_traps;
   snap_t       exp_q[$];
   int unsigned trap_q[$];

   // Reference model: one call per clock, pushes the state expected after the coming edge
   task automatic go();
      logic t;
      if (reset) begin
         m = '0;
         m_traps = 0;
      end else if (m.busy) begin
         m.valid = 1'b0;
         m.wr_en = 1'b0;
         if (exc_ack) begin
            m.busy = 1'b0;
            m.exc_req = 1'b0;
         end
      end else if (flush) begin
         m.valid = 1'b0;
         m.wr_en = 1'b0;
      end else if (!stall) begin
         if (in_valid) begin
            t = in_sign & in_V;
            m.valid = 1'b1;
            m.s = in_S;
            m.z = in_Z;
            m.v = in_V;
            m.n = in_N;
            m.addr = in_wr_addr;
            m.wr_en = in_wr_en & ~t;
            if (t) begin
               m.busy = 1'b1;
               m.exc_req = 1'b1;
               m.epc = in_pc;
               m_traps++;
            end
         end else begin
            m.valid = 1'b0;
            m.wr_en = 1'b0;
         end
      end
      exp_q.push_back(m);
      trap_q.push_back(m_traps);
      @(negedge clk);
   endtask

   task automatic op(input logic v, input logic [31:0] s, input logic ov, input logic sg,
                     input logic we, input logic [4:0] a, input logic [31:0] pc);
      in_valid = v;
      in_S = s;
      in_Z = (s == 32'h0);
      in_N = s[31];
      in_V = ov;
      in_sign = sg;
      in_wr_en = we;
      in_wr_addr = a;
      in_pc = pc;
   endtask

   // Monitor: compares both builds against the popped expectation just after each edge
   initial begin
      snap_t       e, a, b;
      int unsigned n;
      logic [15:0] c16;
      logic [1:0]  c2;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = trap_q.pop_front();
            c16 = (n > 65535) ? 16'hFFFF : n[15:0];
            c2 = (n > 3) ? 2'd3 : n[1:0];
            a = {out_valid, out_S, out_Z, out_V, out_N, out_wr_en, out_wr_addr, exc_req, exc_pc, busy};
            b = {s_valid, s_S, s_Z, s_V, s_N, s_wr_en, s_wr_addr, s_exc_req, s_exc_pc, s_busy};
            checks++;
            if (a !== e || trap_cnt !== c16) begin
               errors++;
               $display("FAIL main cyc=%0d got snap=%h cnt=%h exp snap=%h cnt=%h", cyc, a, trap_cnt, e, c16);
            end
            checks++;
            if (b !== e || s_cnt !== c2) begin
               errors++;
               $display("FAIL sat2 cyc=%0d got snap=%h cnt=%h exp snap=%h cnt=%h", cyc, b, s_cnt, e, c2);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; exc_ack = 1'b0;
      op(0, 0, 0, 0, 0, 0, 0);
      m = '0;
      m_traps = 0;
      go(); go();
      reset = 1'b0;
      op(1, 32'h7FFF_FFFF, 0, 1, 1, 5, 32'h0040_0000); go();
      op(0, 0, 0, 0, 0, 0, 0); go();
      op(1, 32'h8000_0000, 1, 1, 1, 7, 32'h0040_0010); go();
      op(1, 32'h1234_5678, 1, 1, 1, 9, 32'h0040_0014); go();
      stall = 1'b1; go(); stall = 1'b0;
      flush = 1'b1; go(); flush = 1'b0;
      exc_ack = 1'b1; go(); exc_ack = 1'b0;
      op(0, 0, 0, 0, 0, 0, 0); go(); go();
      op(1, 32'h0000_0000, 1, 0, 1, 3, 32'h0040_0020); go();
      exc_ack = 1'b1; go(); exc_ack = 1'b0;
      stall = 1'b1;
      op(1, 32'h8000_0001, 1, 1, 1, 4, 32'h0040_0030); go(); go();
      stall = 1'b0; go();
      op(0, 0, 0, 0, 0, 0, 0); go();
      exc_ack = 1'b1; flush = 1'b1; go(); exc_ack = 1'b0; flush = 1'b0;
      flush = 1'b1;
      op(1, 32'h0000_0042, 1, 1, 1, 6, 32'h0040_0040); go(); flush = 1'b0;
      go();
      reset = 1'b1; op(0, 0, 0, 0, 0, 0, 0); go(); reset = 1'b0; go();
      for (int i = 0; i < 5; i++) begin
         op(1, 32'h7000_0000 + i, 1, 1, 1, 5'(i), 32'h0040_1000 + 4 * i); go();
         op(0, 0, 0, 0, 0, 0, 0); go();
         exc_ack = 1'b1; go(); exc_ack = 1'b0;
      end
      for (int i = 0; i < 1500; i++) begin
         reset = ($urandom_range(0, 99) < 2);
         stall = ($urandom_range(0, 99) < 15);
         flush = ($urandom_range(0, 99) < 10);
         exc_ack = ($urandom_range(0, 99) < 30);
         op($urandom_range(0, 99) < 70, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom(),
            $urandom_range(0, 99) < 20, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 31)), $urandom());
         go();
      end
      reset = 1'b0; stall = 1'b0; flush = 1'b0; exc_ack = 1'b1;
      op(0, 0, 0, 0, 0, 0, 0); go(); exc_ack = 1'b0; go();
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending exp 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
